// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM encoding,
// port-select values, data width and the registered memory command payload.
package mem_arb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 10;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DM = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACC = 2'd1,
      DM_ACC = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic              rd;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts cycles without Mem_Ack and flags the cycle whose
// closing edge would bring the count to the limit.
module mem_arb_timer
   import mem_arb_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Combinational so the FSM can leave ACC on the same edge the count hits the limit.
   assign expired = enable && (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one shared memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: DM priority).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 30,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              IF_Read,
   input  logic [ADDR_W-1:0] IF_Addr,
   output logic [DATA_W-1:0] IF_DataOut,
   output logic              IF_Ready,
   input  logic              DM_Read,
   input  logic [BE_W-1:0]   DM_Write,
   input  logic [ADDR_W-1:0] DM_Addr,
   input  logic [DATA_W-1:0] DM_DataIn,
   output logic [DATA_W-1:0] DM_DataOut,
   output logic              DM_Ready,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_DataOut,
   output logic              Mem_Read,
   output logic [BE_W-1:0]   Mem_Write,
   input  logic [DATA_W-1:0] Mem_DataIn,
   input  logic              Mem_Ack,
   output logic              Mem_Error
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] dm_data_q, dm_data_d;
   logic              if_ready_q, if_ready_d;
   logic              dm_ready_q, dm_ready_d;
   logic              mem_error_q, mem_error_d;

   logic              if_req, dm_req, grant, pick_dm, gnt_port;
   logic              acc_wait, tmo_expired;
   logic [DATA_W-1:0] rsp_data;

   assign if_req   = IF_Read;
   assign dm_req   = DM_Read || (DM_Write != '0);
   assign grant    = (state_q == IDLE) && (if_req || dm_req);
   assign acc_wait = ((state_q == IF_ACC) || (state_q == DM_ACC)) && !Mem_Ack;
   assign gnt_port = pick_dm ? PORT_DM : PORT_IF;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On a tie, the port that did not win the previous grant goes next.
   assign pick_dm = dm_req && (!if_req || (last_q == PORT_IF));
   assign last_d  = grant ? gnt_port : last_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= PORT_IF;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign pick_dm = dm_req;
`endif

   mem_arb_timer u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (grant),
      .enable  (acc_wait),
      .limit   (LIMIT),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cmd_d       = cmd_q;
      if_data_d   = if_data_q;
      dm_data_d   = dm_data_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      mem_error_d = mem_error_q;
      rsp_data    = '0;

      case (state_q)
         IDLE: begin
            if (grant) begin
               if (gnt_port == PORT_DM) begin
                  state_d     = DM_ACC;
                  addr_d      = DM_Addr;
                  // Any byte enable makes this a write, even with DM_Read high.
                  cmd_d.rd    = (DM_Write == '0);
                  cmd_d.be    = DM_Write;
                  cmd_d.wdata = DM_DataIn;
               end else begin
                  state_d     = IF_ACC;
                  addr_d      = IF_Addr;
                  cmd_d.rd    = 1'b1;
                  cmd_d.be    = '0;
                  cmd_d.wdata = '0;
               end
            end
         end
         IF_ACC, DM_ACC: begin
            if (Mem_Ack || tmo_expired) begin
               state_d  = RESP;
               cmd_d.rd = 1'b0;
               cmd_d.be = '0;
               rsp_data = (Mem_Ack && cmd_q.rd) ? Mem_DataIn : '0;
               if (!Mem_Ack) begin
                  mem_error_d = 1'b1;
               end
               if (state_q == IF_ACC) begin
                  if_data_d  = rsp_data;
                  if_ready_d = 1'b1;
               end else begin
                  dm_data_d  = rsp_data;
                  dm_ready_d = 1'b1;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cmd_q       <= '0;
         if_data_q   <= '0;
         dm_data_q   <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cmd_q       <= cmd_d;
         if_data_q   <= if_data_d;
         dm_data_q   <= dm_data_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign IF_DataOut  = if_data_q;
   assign IF_Ready    = if_ready_q;
   assign DM_DataOut  = dm_data_q;
   assign DM_Ready    = dm_ready_q;
   assign Mem_Addr    = addr_q;
   assign Mem_DataOut = cmd_q.wdata;
   assign Mem_Read    = cmd_q.rd;
   assign Mem_Write   = cmd_q.be;
   assign Mem_Error   = mem_error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model of grant order and timeout.
module tb_mem_port_arbiter;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        IF_Read = 1'b0;
   logic [29:0] IF_Addr = '0;
   logic [31:0] IF_DataOut;
   logic        IF_Ready;
   logic        DM_Read = 1'b0;
   logic [3:0]  DM_Write = '0;
   logic [29:0] DM_Addr = '0;
   logic [31:0] DM_DataIn = '0;
   logic [31:0] DM_DataOut;
   logic        DM_Ready;
   logic [29:0] Mem_Addr;
   logic [31:0] Mem_DataOut;
   logic        Mem_Read;
   logic [3:0]  Mem_Write;
   logic [31:0] Mem_DataIn = '0;
   logic        Mem_Ack = 1'b0;
   logic        Mem_Error;

   int total = 0;
   int bad   = 0;
   bit exp_err = 1'b0;
   bit last_grant = 1'b0;   // 0 = IF, 1 = DM

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(30), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset_n(reset_n),
      .IF_Read(IF_Read), .IF_Addr(IF_Addr), .IF_DataOut(IF_DataOut), .IF_Ready(IF_Ready),
      .DM_Read(DM_Read), .DM_Write(DM_Write), .DM_Addr(DM_Addr), .DM_DataIn(DM_DataIn),
      .DM_DataOut(DM_DataOut), .DM_Ready(DM_Ready),
      .Mem_Addr(Mem_Addr), .Mem_DataOut(Mem_DataOut), .Mem_Read(Mem_Read),
      .Mem_Write(Mem_Write), .Mem_DataIn(Mem_DataIn), .Mem_Ack(Mem_Ack), .Mem_Error(Mem_Error)
   );

   function automatic bit model_dm_wins(input bit want_if, input bit want_dm);
      if (!want_dm) return 1'b0;
      if (!want_if) return 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (last_grant == 1'b0);
`else
      return 1'b1;
`endif
   endfunction

   // Plays the memory for one granted access; entered at the negedge of the IDLE
   // cycle in which the request is sampled, returns at the negedge of the next IDLE cycle.
   task automatic run_access(input bit port, input logic [29:0] addr, input bit rd,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int d);
      bit          tmo;
      int          ncyc;
      logic [31:0] exp_data;
      tmo  = (d >= TMO);
      ncyc = tmo ? TMO : d + 1;
      last_grant = port;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clock);
         total++;
         if (Mem_Read !== rd) begin bad++; $display("FAIL acc_rd c=%0d: got %0b want %0b", c, Mem_Read, rd); end
         total++;
         if (Mem_Write !== be) begin bad++; $display("FAIL acc_be c=%0d: got %0h want %0h", c, Mem_Write, be); end
         total++;
         if (Mem_Addr !== addr) begin bad++; $display("FAIL acc_addr c=%0d: got %0h want %0h", c, Mem_Addr, addr); end
         if (!rd) begin
            total++;
            if (Mem_DataOut !== wdata) begin bad++; $display("FAIL acc_wdata: got %0h want %0h", Mem_DataOut, wdata); end
         end
         total++;
         if ({IF_Ready, DM_Ready} !== 2'b00) begin bad++; $display("FAIL acc_ready c=%0d: got %b want 00", c, {IF_Ready, DM_Ready}); end
         Mem_Ack    = (c == d + 1);
         Mem_DataIn = (c == d + 1) ? rdata : $urandom;
      end
      @(negedge clock);
      if (tmo) exp_err = 1'b1;
      exp_data = (rd && !tmo) ? rdata : 32'h0;
      total++;
      if ({IF_Ready, DM_Ready} !== {~port, port}) begin
         bad++; $display("FAIL resp_ready: got %b want %b", {IF_Ready, DM_Ready}, {~port, port});
      end
      total++;
      if ((port ? DM_DataOut : IF_DataOut) !== exp_data) begin
         bad++; $display("FAIL resp_data port=%0d: got %0h want %0h", port, (port ? DM_DataOut : IF_DataOut), exp_data);
      end
      total++;
      if ({Mem_Read, Mem_Write} !== 5'b0) begin bad++; $display("FAIL resp_strobe: got %b want 0", {Mem_Read, Mem_Write}); end
      total++;
      if (Mem_Error !== exp_err) begin bad++; $display("FAIL resp_err: got %0b want %0b", Mem_Error, exp_err); end
      // Stray acks in RESP and IDLE must be ignored.
      Mem_Ack    = 1'($urandom_range(0, 1));
      Mem_DataIn = $urandom;
      if (port) begin DM_Read = 1'b0; DM_Write = 4'b0; end
      else IF_Read = 1'b0;
      @(negedge clock);
      total++;
      if ({IF_Ready, DM_Ready, Mem_Read} !== 3'b000) begin
         bad++; $display("FAIL idle_quiet: got %b want 000", {IF_Ready, DM_Ready, Mem_Read});
      end
      Mem_Ack = 1'($urandom_range(0, 1));
   endtask

   task automatic run_txn(input bit want_if, input bit want_dm, input logic [29:0] ia,
                          input logic [29:0] da, input bit dm_rd, input logic [3:0] dm_be,
                          input logic [31:0] dm_wd, input int d_if, input int d_dm,
                          input logic [31:0] rd_if, input logic [31:0] rd_dm);
      bit dm_first;
      bit dm_is_rd;
      IF_Read   = want_if;
      IF_Addr   = ia;
      DM_Read   = want_dm && dm_rd;
      DM_Write  = want_dm ? dm_be : 4'b0;
      DM_Addr   = da;
      DM_DataIn = dm_wd;
      dm_is_rd  = (dm_be == 4'b0);
      dm_first  = model_dm_wins(want_if, want_dm);
      if (dm_first) begin
         run_access(1'b1, da, dm_is_rd, dm_is_rd ? 4'b0 : dm_be, dm_wd, rd_dm, d_dm);
         if (want_if) run_access(1'b0, ia, 1'b1, 4'b0, 32'h0, rd_if, d_if);
      end else if (want_if) begin
         run_access(1'b0, ia, 1'b1, 4'b0, 32'h0, rd_if, d_if);
         if (want_dm) run_access(1'b1, da, dm_is_rd, dm_is_rd ? 4'b0 : dm_be, dm_wd, rd_dm, d_dm);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clock);
      total++;
      if ({IF_Ready, DM_Ready, Mem_Read, Mem_Write, Mem_Error} !== 8'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0", {IF_Ready, DM_Ready, Mem_Read, Mem_Write, Mem_Error});
      end
      total++;
      if ({Mem_Addr, Mem_DataOut, IF_DataOut, DM_DataOut} !== 126'b0) begin
         bad++; $display("FAIL reset_data: got %0h want 0", {Mem_Addr, Mem_DataOut, IF_DataOut, DM_DataOut});
      end
      reset_n    = 1'b1;
      exp_err    = 1'b0;
      last_grant = 1'b0;
   endtask

   task automatic test_basic_fetch;
      run_txn(1'b1, 1'b0, 30'h100, 30'h0, 1'b0, 4'h0, 32'h0, 2, 0, 32'hDEADBEEF, 32'h0);
   endtask

   task automatic test_ack_on_timeout;
      run_txn(1'b1, 1'b0, 30'h140, 30'h0, 1'b0, 4'h0, 32'h0, TMO - 1, 0, 32'h1234_5678, 32'h0);
      run_txn(1'b0, 1'b1, 30'h0, 30'h180, 1'b1, 4'h0, 32'h0, 0, TMO - 1, 32'h0, 32'hCAFE_F00D);
   endtask

   task automatic test_priority;
      run_txn(1'b1, 1'b1, 30'h200, 30'h300, 1'b0, 4'b1111, 32'hA5A5_5A5A, 0, 0, 32'h1111_2222, 32'h0);
      run_txn(1'b1, 1'b1, 30'h204, 30'h304, 1'b1, 4'b0000, 32'h0, 0, 1, 32'h3333_4444, 32'h5555_6666);
   endtask

   task automatic test_rw_conflict;
      run_txn(1'b0, 1'b1, 30'h0, 30'h3C0, 1'b1, 4'b0011, 32'h0BAD_C0DE, 0, 1, 32'h0, 32'hFFFF_FFFF);
   endtask

   task automatic test_timeout;
      run_txn(1'b0, 1'b1, 30'h0, 30'h400, 1'b1, 4'b0000, 32'h0, 0, 9, 32'h0, 32'h7777_7777);
      run_txn(1'b1, 1'b0, 30'h404, 30'h0, 1'b0, 4'h0, 32'h0, 1, 0, 32'h8888_9999, 32'h0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 30; n++) begin
         int         sel;
         bit         dm_rd;
         logic [3:0] be;
         sel   = $urandom_range(0, 3);
         dm_rd = 1'($urandom_range(0, 1));
         be    = 4'($urandom_range(0, 15));
         if (!dm_rd && be == 4'b0) dm_rd = 1'b1;
         run_txn(sel != 1, sel != 0, 30'($urandom), 30'($urandom), dm_rd, be, $urandom,
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom);
      end
   endtask

   task automatic test_reset_mid;
      logic [29:0] ia;
      logic [29:0] da;
      ia = 30'h2AB0;
      da = 30'h3CD0;
      DM_Read = 1'b1;
      DM_Addr = da;
      @(negedge clock);
      total++;
      if ({Mem_Read, Mem_Addr} !== {1'b1, da}) begin
         bad++; $display("FAIL mid_grant: got %0h want %0h", {Mem_Read, Mem_Addr}, {1'b1, da});
      end
      Mem_Ack = 1'b0;
      IF_Read = 1'b1;
      IF_Addr = ia;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({IF_Ready, DM_Ready, Mem_Read, Mem_Write, Mem_Error} !== 8'b0) begin
         bad++; $display("FAIL mid_reset_ctrl: got %b want 0", {IF_Ready, DM_Ready, Mem_Read, Mem_Write, Mem_Error});
      end
      total++;
      if ({Mem_Addr, Mem_DataOut, IF_DataOut, DM_DataOut} !== 126'b0) begin
         bad++; $display("FAIL mid_reset_data: got %0h want 0", {Mem_Addr, Mem_DataOut, IF_DataOut, DM_DataOut});
      end
      DM_Read    = 1'b0;
      exp_err    = 1'b0;
      last_grant = 1'b0;
      @(negedge clock);
      total++;
      if ({IF_Ready, DM_Ready, Mem_Read} !== 3'b000) begin
         bad++; $display("FAIL mid_in_reset: got %b want 000", {IF_Ready, DM_Ready, Mem_Read});
      end
      reset_n = 1'b1;
      run_access(1'b0, ia, 1'b1, 4'b0, 32'h0, 32'h600D_F00D, 1);
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_ack_on_timeout();
      test_priority();
      test_rw_conflict();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
